// File: rtl/pkg_ft601_ctrl_defines.sv
// Shared FT601 controller definitions: channel count, data width and the
// master-RAM arbiter types.
package pkg_ft601_ctrl_defines;

    localparam int CNT_CHANNLS = 4;
    localparam int WIDTH_DATA  = 32;
    localparam int CH_IDX_W    = (CNT_CHANNLS > 1) ? $clog2(CNT_CHANNLS) : 1;

    typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_t;
    typedef logic [CH_IDX_W-1:0] ch_idx_t;

    function automatic logic [CNT_CHANNLS-1:0] ch_onehot(input ch_idx_t idx);
        logic [CNT_CHANNLS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Cyclic successor; CNT_CHANNLS need not be a power of two.
    function automatic ch_idx_t ch_next(input ch_idx_t idx);
        return (int'(idx) == CNT_CHANNLS - 1) ? ch_idx_t'(0) : ch_idx_t'(idx + 1'b1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr,
// searched cyclically.
module rr_pick
    import pkg_ft601_ctrl_defines::*;
(
    input  logic [CNT_CHANNLS-1:0] req,
    input  ch_idx_t                ptr,
    output logic                   found,
    output ch_idx_t                win
);

    always_comb begin
        int      idx;
        ch_idx_t c;
        idx   = 0;
        c     = '0;
        found = 1'b0;
        win   = ptr;
        // Scan from the far end so the last hit written is the closest to ptr.
        for (int k = CNT_CHANNLS - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % CNT_CHANNLS;
            c   = ch_idx_t'(idx);
            if (req[c]) begin
                found = 1'b1;
                win   = c;
            end
        end
    end

endmodule

// File: rtl/fifo_mst_ram_arb.sv
// Round-robin arbiter sharing the single-port FT600 master RAM between
// channels, with locked bursts and a fixed 2-cycle read return path.
module fifo_mst_ram_arb
    import pkg_ft601_ctrl_defines::*;
#(
    parameter int T_MSZ     = 12,
    parameter int MAX_BURST = 16
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic [CNT_CHANNLS-1:0]                ch_req,
    input  logic [CNT_CHANNLS-1:0]                ch_we,
    input  logic [CNT_CHANNLS-1:0]                ch_lock,
    input  logic [CNT_CHANNLS*T_MSZ-1:0]          ch_addr,
    input  logic [CNT_CHANNLS*(WIDTH_DATA+1)-1:0] ch_din,
    output logic [CNT_CHANNLS-1:0]                ch_gnt,
    output logic [CNT_CHANNLS-1:0]                ch_rvalid,
    output logic [WIDTH_DATA-1:0]                 ch_rdata,
    input  logic                                  mem_rdy,
    input  logic [WIDTH_DATA-1:0]                 mem_do,
    output logic                                  mem_en,
    output logic [CNT_CHANNLS-1:0]                wr_en,
    output logic [T_MSZ-1:0]                      mem_addr,
    output logic [WIDTH_DATA:0]                   mem_din
);

    localparam int               CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    arb_state_t       state, state_nxt;
    ch_idx_t          ptr, owner, pick, sel, rd_id;
    logic [CNT_W-1:0] beat_cnt;
    logic             lock_q, found, hold, accept, rd_vld;

    rr_pick u_pick (
        .req   (ch_req),
        .ptr   (ptr),
        .found (found),
        .win   (pick)
    );

    // lock_q is the lock the owner presented with its last beat: it asks to
    // keep the RAM for the following beat, so dropping it still gets the
    // current beat and releases on the next one.
    assign hold   = (state == ARB_OWN) && ch_req[owner] && lock_q && (beat_cnt < BURST_MAX);
    assign sel    = hold ? owner : pick;
    assign accept = mem_rdy && (hold || found);
    assign ch_gnt = accept ? ch_onehot(sel) : '0;

    assign ch_rdata = mem_do;

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: if (accept) state_nxt = ARB_OWN;
            ARB_OWN:  if (mem_rdy && ch_req == '0) state_nxt = ARB_IDLE;
            default:  state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ARB_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr       <= '0;
            owner     <= '0;
            beat_cnt  <= '0;
            lock_q    <= 1'b0;
            mem_en    <= 1'b0;
            wr_en     <= '0;
            mem_addr  <= '0;
            mem_din   <= '0;
            rd_vld    <= 1'b0;
            rd_id     <= '0;
            ch_rvalid <= '0;
        end else begin
            mem_en    <= accept;
            wr_en     <= (accept && ch_we[sel]) ? ch_onehot(sel) : '0;
            // RAM answers one cycle after the command register, so the
            // channel id rides two stages alongside it.
            rd_vld    <= accept && !ch_we[sel];
            rd_id     <= sel;
            ch_rvalid <= rd_vld ? ch_onehot(rd_id) : '0;
            if (accept) begin
                mem_addr <= ch_addr[sel*T_MSZ +: T_MSZ];
                mem_din  <= ch_din[sel*(WIDTH_DATA+1) +: WIDTH_DATA+1];
                lock_q   <= ch_lock[sel];
                if (hold) begin
                    beat_cnt <= beat_cnt + 1'b1;
                end else begin
                    owner    <= pick;
                    ptr      <= ch_next(pick);
                    beat_cnt <= CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_mst_ram_arb.sv
// Directed self-checking bench for fifo_mst_ram_arb with a behavioural
// single-port RAM answering one cycle after mem_en.
module tb_fifo_mst_ram_arb;
    import pkg_ft601_ctrl_defines::*;

    localparam int T_MSZ = 12;
    localparam int AW    = CNT_CHANNLS * T_MSZ;
    localparam int DW    = CNT_CHANNLS * (WIDTH_DATA + 1);

    logic                   clk, rstn;
    logic [CNT_CHANNLS-1:0] ch_req, ch_we, ch_lock, ch_gnt, ch_rvalid, wr_en;
    logic [AW-1:0]          ch_addr;
    logic [DW-1:0]          ch_din;
    logic [WIDTH_DATA-1:0]  ch_rdata, mem_do;
    logic                   mem_rdy, mem_en;
    logic [T_MSZ-1:0]       mem_addr;
    logic [WIDTH_DATA:0]    mem_din;

    logic [WIDTH_DATA-1:0]  ram [0:(1<<T_MSZ)-1];
    logic [3:0]             eg [8];
    logic                   rdy_v [8];
    int                     errors = 0;
    int                     checks = 0;

    fifo_mst_ram_arb #(.T_MSZ(T_MSZ), .MAX_BURST(4)) dut (
        .clk(clk), .rstn(rstn), .ch_req(ch_req), .ch_we(ch_we), .ch_lock(ch_lock),
        .ch_addr(ch_addr), .ch_din(ch_din), .ch_gnt(ch_gnt), .ch_rvalid(ch_rvalid),
        .ch_rdata(ch_rdata), .mem_rdy(mem_rdy), .mem_do(mem_do), .mem_en(mem_en),
        .wr_en(wr_en), .mem_addr(mem_addr), .mem_din(mem_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (|wr_en) ram[mem_addr] <= mem_din[WIDTH_DATA-1:0];
            else        mem_do        <= ram[mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rstn = 1'b0; mem_do = '0;
        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            ch_req  = CNT_CHANNLS'($urandom);
            ch_we   = CNT_CHANNLS'($urandom);
            ch_lock = CNT_CHANNLS'($urandom);
            ch_addr = AW'({2{$urandom}});
            ch_din  = DW'({5{$urandom}});
            mem_rdy = 1'($urandom);
            tick();
            chk("rst_mem_en", mem_en, 1'b0);
            chk("rst_wr_en", wr_en, 4'b0);
            chk("rst_mem_addr", mem_addr, 12'h0);
            chk("rst_mem_din", mem_din, 33'h0);
            chk("rst_rvalid", ch_rvalid, 4'b0);
        end
        ch_req = '0; ch_we = '0; ch_lock = '0; ch_addr = '0; ch_din = '0; mem_rdy = 1'b1;
        #1;
        rstn = 1'b1;

        // ch0 and ch1 together: ch0 first
        ch_req = 4'b0011;
        #1; chk("post_rst_first", ch_gnt, 4'b0001);
        tick(); #1; chk("post_rst_second", ch_gnt, 4'b0010);
        chk("post_rst_mem_en", mem_en, 1'b1);
        ch_req = '0;
        repeat (3) tick();

        // ch1 write then read back
        ch_req = 4'b0010; ch_we = 4'b0010;
        ch_addr[1*T_MSZ +: T_MSZ] = 12'h010;
        ch_din[1*(WIDTH_DATA+1) +: WIDTH_DATA+1] = 33'h1_2345_6789;
        #1; chk("wr_gnt", ch_gnt, 4'b0010);
        tick(); ch_req = '0; ch_we = '0; #1;
        chk("wr_mem_en", mem_en, 1'b1);
        chk("wr_wr_en", wr_en, 4'b0010);
        chk("wr_mem_addr", mem_addr, 12'h010);
        chk("wr_mem_din", mem_din, 33'h1_2345_6789);
        tick();
        chk("wr_idle_mem_en", mem_en, 1'b0);
        chk("wr_no_rvalid", ch_rvalid, 4'b0);
        ch_req = 4'b0010;
        #1; chk("rd_gnt", ch_gnt, 4'b0010);
        tick(); ch_req = '0; #1;
        chk("rd_mem_en", mem_en, 1'b1);
        chk("rd_wr_en", wr_en, 4'b0);
        chk("rd_rvalid_t1", ch_rvalid, 4'b0);
        tick();
        chk("rd_rvalid_t2", ch_rvalid, 4'b0010);
        chk("rd_rdata", ch_rdata, 32'h2345_6789);
        tick();
        chk("rd_rvalid_t3", ch_rvalid, 4'b0);
        repeat (2) tick();

        // Unlocked ch0/ch2 reads: ptr sits at 2, so ch2 leads
        eg = '{4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0000, 4'b0000};
        for (int k = 0; k < 8; k++) begin
            ch_req = (k < 6) ? 4'b0101 : 4'b0000;
            #1;
            chk("rr_gnt", ch_gnt, eg[k]);
            chk("rr_rvalid", ch_rvalid, (k >= 2) ? eg[k-2] : 4'b0000);
            if (k >= 1) chk("rr_mem_en", mem_en, eg[k-1] != 4'b0);
            tick();
        end
        repeat (3) tick();

        // ch3 single beat moves ptr to 0, then locked ch0 burst of 4
        ch_req = 4'b1000;
        #1; chk("pre_burst_gnt", ch_gnt, 4'b1000);
        tick();
        eg = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0001, 4'b0000, 4'b0000};
        ch_req = 4'b0101; ch_lock = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            #1; chk("burst_gnt", ch_gnt, eg[k]);
            tick();
        end
        ch_req = '0; ch_lock = '0;
        repeat (4) tick();

        // Locked ch1 burst with a 3-cycle mem_rdy stall
        eg    = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0100};
        rdy_v = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        ch_req = 4'b0110; ch_lock = 4'b0010;
        for (int k = 0; k < 8; k++) begin
            mem_rdy = rdy_v[k];
            #1;
            chk("stall_gnt", ch_gnt, eg[k]);
            if (k >= 1) chk("stall_mem_en", mem_en, eg[k-1] != 4'b0);
            tick();
        end
        ch_req = '0; ch_lock = '0; mem_rdy = 1'b1;
        repeat (4) tick();

        // Reset right after a read is accepted
        ch_req = 4'b0001;
        #1; chk("rst_rd_gnt", ch_gnt, 4'b0001);
        tick();
        ch_req = '0; rstn = 1'b0;
        #1;
        chk("rst_rd_mem_en", mem_en, 1'b0);
        chk("rst_rd_rvalid_a", ch_rvalid, 4'b0);
        tick();
        chk("rst_rd_rvalid_b", ch_rvalid, 4'b0);
        rstn = 1'b1;
        tick();
        chk("rst_rd_rvalid_c", ch_rvalid, 4'b0);
        ch_req = 4'b0011;
        #1; chk("rst_rd_ptr0", ch_gnt, 4'b0001);
        tick(); ch_req = '0; #1;
        chk("rst_rd_new_mem_en", mem_en, 1'b1);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_mst_ram_arb.md
Name: fifo_mst_ram_arb

Overview:
- Arbiter/sequencer sharing the single-port FT600 master RAM (fifo_mst_ram) between CNT_CHANNLS channel requesters.
- Grants one RAM access per cycle using round-robin priority, with optional locked bursts of up to MAX_BURST beats.
- Drives the RAM command pins from registers and routes read data back to the issuing channel with a fixed 2-cycle latency.

Parameters:
- T_MSZ, 12: RAM address width; must match fifo_mst_ram.
- MAX_BURST, 16: maximum consecutive beats a locked owner may hold the RAM. Legal range 1..256.
- CNT_CHANNLS, WIDTH_DATA: taken from pkg_ft601_ctrl_defines, not parameters of this block.

Ports:
- clk  in  1  single clock.
- rstn  in  1  asynchronous active-low reset.
- ch_req  in  CNT_CHANNLS  per-channel access request, held until granted.
- ch_we  in  CNT_CHANNLS  1 = write, 0 = read.
- ch_lock  in  CNT_CHANNLS  request to keep ownership for the next beat.
- ch_addr  in  CNT_CHANNLS*T_MSZ  flattened per-channel address; channel i at [i*T_MSZ +: T_MSZ].
- ch_din  in  CNT_CHANNLS*(WIDTH_DATA+1)  flattened per-channel write data.
- ch_gnt  out  CNT_CHANNLS  one-hot, combinational; beat accepted this cycle.
- ch_rvalid  out  CNT_CHANNLS  one-hot; read data valid for that channel.
- ch_rdata  out  WIDTH_DATA  shared read data, direct from mem_do.
- mem_rdy  in  1  RAM ready.
- mem_en  out  1  RAM enable.
- wr_en  out  CNT_CHANNLS  one-hot of the owning channel on a write, else 0.
- mem_addr  out  T_MSZ  RAM address.
- mem_din  out  WIDTH_DATA+1  RAM write data.

Behaviour:
- Reset: one clock, rstn asynchronous active-low. While rstn=0, all registered outputs are 0 (mem_en, wr_en, mem_addr, mem_din, ch_rvalid), state=IDLE, ptr=0, beat_cnt=0.
- Acceptance: a beat is accepted only when mem_rdy=1. ch_gnt[i]=1 iff channel i is selected and mem_rdy=1. With mem_rdy=0, ch_gnt=0 and all state and counters hold.
- Selection, in priority order:
  - If state=OWN, ch_req[owner]=1, ch_lock[owner]=1 and beat_cnt<MAX_BURST, owner is selected.
  - Otherwise the first requester at or after ptr, searched cyclically, is selected. This is zero-bubble: no idle cycle between owners.
- On a new owner: owner=winner, ptr=(winner+1) mod CNT_CHANNLS, beat_cnt=1, state=OWN.
- On a continued owner: beat_cnt increments, saturating at MAX_BURST.
- State: IDLE->OWN on any accept. OWN->IDLE when mem_rdy=1 and ch_req is all 0. Unlocked traffic is pure per-beat round-robin.
- Latency, for a beat accepted at cycle t:
  - At t+1: mem_en=1, mem_addr, mem_din and wr_en are registered from the winner's inputs.
  - If no beat is accepted at t, mem_en=0 and wr_en=0 at t+1.
  - For a read, ch_rvalid[owner]=1 at t+2 with ch_rdata=mem_do.
  - Writes never assert ch_rvalid.
- Read tracking: a 2-stage pipeline of {valid, channel id}. Back-to-back reads from different channels each return exactly once, in order.
- Boundaries:
  - MAX_BURST=1 makes every beat a rotation point.
  - Owner lowering ch_lock on a beat: that beat is still granted; rotation happens on the next cycle.
  - Owner dropping ch_req mid-burst: rotates immediately in the same cycle.
  - ptr wraps from CNT_CHANNLS-1 to 0.
  - Reset mid-operation clears the read pipeline; no ch_rvalid follows reset for pre-reset reads.
- ch_din/ch_addr of non-granted channels are ignored.

Decomposition:
- Add to pkg_ft601_ctrl_defines:
  - CH_IDX_W = $clog2(CNT_CHANNLS), minimum 1.
  - typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_t.
  - typedef logic [CH_IDX_W-1:0] ch_idx_t.
- Sub-module rr_pick: combinational round-robin picker. Inputs are the request vector and ptr; outputs are a found flag and the winner index.

Test Plan:
- Reset: hold rstn=0 with random inputs -> all outputs 0. After release, ch0 and ch1 requesting together -> ch0 wins first (ptr=0).
- ch1 writes addr 0x010, data 0x1_2345_6789, then reads addr 0x010:
  - Write: ch_gnt=0b0010 at t; mem_en=1 and wr_en=0b0010 at t+1.
  - Read: ch_rvalid=0b0010 at read t+2 with ch_rdata=0x2345_6789.
- ch0 and ch2 issue continuous unlocked reads -> grants alternate ch0, ch2, ch0, ... with no idle cycle; rvalid ids follow grants 2 cycles later.
- MAX_BURST=4, ch0 locked and requesting, ch2 requesting -> 4 ch0 beats, then ch2, then ch0 again.
- mem_rdy=0 for 3 cycles mid-burst -> ch_gnt=0 and mem_en=0 for those cycles, beat_cnt holds; the burst resumes to complete 4 beats total.
- rstn asserted the cycle after a read is accepted -> no ch_rvalid; state=IDLE, ptr=0.
